// File: rtl/case_5_mul_pkg.sv
// case_5_mul_pkg
// Shared types and helpers for the case_5 pipelined multiplier.
//   prod_width(a, b) : full product width of an a-bit by b-bit multiply
//   mul_mode_e       : per-transaction operand interpretation
//   mul_res_t        : one pipeline slot {valid, dout, ovf} at the default result width
package case_5_mul_pkg;

  function automatic int prod_width(input int a, input int b);
    return a + b;
  endfunction

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mul_mode_e;

  localparam int RES_DOUT_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [RES_DOUT_W-1:0] dout;
    logic                  ovf;
  } mul_res_t;

endpackage

// File: rtl/case_5_mul_stage.sv
// case_5_mul_stage
// One pipeline register slice: valid bit plus a data word.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_en       : shift enable (pipeline advance)
//   i_clr      : synchronous clear of the valid bit only; data is kept
//   i_valid    : incoming valid
//   i_data     : incoming data word
//   o_valid    : registered valid
//   o_data     : registered data word
module case_5_mul_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/case_5_mul_pipe.sv
// case_5_mul_pipe
// Pipelined signed/unsigned multiplier with result narrowing, overflow flag,
// valid/ready flow control (stall-all) and flush.
// Optional feature macro: CASE_5_MUL_SAT_EN -- saturate dout on overflow
// instead of wrapping; ovf is unaffected.
// Ports:
//   ap_clk, ap_rst_n     : clock, asynchronous active-low reset
//   flush                : drop every in-flight result at the next edge
//   in_valid / in_ready  : operand handshake
//   din0, din1           : operands
//   is_signed            : 1 = two's complement operands, 0 = unsigned
//   out_valid / out_ready: result handshake
//   dout, ovf            : formatted product and overflow flag
module case_5_mul_pipe
  import case_5_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 8,
  parameter int DIN1_WIDTH = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int NUM_STAGE  = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P  = prod_width(DIN0_WIDTH, DIN1_WIDTH);
  localparam int DW = DOUT_WIDTH + 1;

  generate
    if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_bad_num_stage
      $error("case_5_mul_pipe: NUM_STAGE must be in 1..4");
    end
  endgenerate

  mul_mode_e w_mode;
  logic      w_sgn;
  assign w_mode = is_signed ? MODE_SIGNED : MODE_UNSIGNED;
  assign w_sgn  = (w_mode == MODE_SIGNED);

  // Extending both operands to P bits makes a plain P-bit multiply exact in
  // either mode, so one multiplier serves signed and unsigned.
  logic [P-1:0] w_a_ext, w_b_ext, w_prod;
  assign w_a_ext = {{DIN1_WIDTH{w_sgn & din0[DIN0_WIDTH-1]}}, din0};
  assign w_b_ext = {{DIN0_WIDTH{w_sgn & din1[DIN1_WIDTH-1]}}, din1};
  assign w_prod  = w_a_ext * w_b_ext;

  logic [DOUT_WIDTH-1:0] w_fmt_dout;
  logic                  w_fmt_ovf;

  generate
    if (DOUT_WIDTH == P) begin : g_fmt_eq
      assign w_fmt_dout = w_prod;
      assign w_fmt_ovf  = 1'b0;
    end else if (DOUT_WIDTH > P) begin : g_fmt_wide
      assign w_fmt_dout = {{(DOUT_WIDTH - P){w_sgn & w_prod[P-1]}}, w_prod};
      assign w_fmt_ovf  = 1'b0;
    end else begin : g_fmt_narrow
      logic                    w_ext_bit;
      logic [P-DOUT_WIDTH-1:0] w_disc;
      logic [DOUT_WIDTH-1:0]   w_wrap;
      // Discarded bits must all equal what extension of the kept field
      // would produce: its top bit when signed, zero when unsigned.
      assign w_ext_bit = w_sgn & w_prod[DOUT_WIDTH-1];
      assign w_disc    = w_prod[P-1:DOUT_WIDTH];
      assign w_fmt_ovf = (w_disc != {(P - DOUT_WIDTH){w_ext_bit}});
      assign w_wrap    = w_prod[DOUT_WIDTH-1:0];
`ifdef CASE_5_MUL_SAT_EN
      logic [DOUT_WIDTH-1:0] w_sat_max;
      logic [DOUT_WIDTH-1:0] w_sat;
      // All ones for unsigned; shifting in a zero gives the signed maximum.
      assign w_sat_max  = {DOUT_WIDTH{1'b1}} >> w_sgn;
      assign w_sat      = (w_sgn && w_prod[P-1]) ? ~w_sat_max : w_sat_max;
      assign w_fmt_dout = w_fmt_ovf ? w_sat : w_wrap;
`else
      assign w_fmt_dout = w_wrap;
`endif
    end
  endgenerate

  // Stall-all: every slice moves together, bubbles included.
  logic w_advance;
  logic w_accept;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance && !flush && ap_rst_n;
  assign w_accept  = in_valid && in_ready;

  logic [NUM_STAGE:1] w_vld;
  logic [DW-1:0]      w_dat [1:NUM_STAGE];

  genvar gi;
  generate
    for (gi = 1; gi <= NUM_STAGE; gi++) begin : g_stage
      logic          w_in_vld;
      logic [DW-1:0] w_in_dat;
      if (gi == 1) begin : g_first
        assign w_in_vld = w_accept;
        assign w_in_dat = {w_fmt_ovf, w_fmt_dout};
      end else begin : g_rest
        assign w_in_vld = w_vld[gi-1];
        assign w_in_dat = w_dat[gi-1];
      end
      case_5_mul_stage #(
        .W (DW)
      ) u_stage (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_en    (w_advance),
        .i_clr   (flush),
        .i_valid (w_in_vld),
        .i_data  (w_in_dat),
        .o_valid (w_vld[gi]),
        .o_data  (w_dat[gi])
      );
    end
  endgenerate

  assign out_valid = w_vld[NUM_STAGE];
  assign dout      = w_dat[NUM_STAGE][DOUT_WIDTH-1:0];
  assign ovf       = w_dat[NUM_STAGE][DOUT_WIDTH];

endmodule

// File: tb/tb_case_5_mul_pipe.sv
module tb_case_5_mul_pipe;

  localparam int NS = 3;

`ifdef CASE_5_MUL_SAT_EN
  localparam logic [7:0] E_100X2 = 8'h7F;
  localparam logic [7:0] E_FFXFF = 8'hFF;
  localparam logic [7:0] E_M128  = 8'h7F;
`else
  localparam logic [7:0] E_100X2 = 8'hC8;
  localparam logic [7:0] E_FFXFF = 8'h01;
  localparam logic [7:0] E_M128  = 8'h00;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  din0;
  logic [7:0]  din1;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  dout;
  logic        ovf;

  logic        in_valid16;
  logic        in_ready16;
  logic        out_valid16;
  logic [15:0] dout16;
  logic        ovf16;

  always #5 ap_clk = ~ap_clk;

  case_5_mul_pipe #(
    .DIN0_WIDTH (8), .DIN1_WIDTH (8), .DOUT_WIDTH (8), .NUM_STAGE (NS)
  ) u_dut (
    .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .flush (flush),
    .in_valid (in_valid), .in_ready (in_ready),
    .din0 (din0), .din1 (din1), .is_signed (is_signed),
    .out_valid (out_valid), .out_ready (out_ready),
    .dout (dout), .ovf (ovf)
  );

  case_5_mul_pipe #(
    .DIN0_WIDTH (8), .DIN1_WIDTH (8), .DOUT_WIDTH (16), .NUM_STAGE (1)
  ) u_dut16 (
    .ap_clk (ap_clk), .ap_rst_n (ap_rst_n), .flush (1'b0),
    .in_valid (in_valid16), .in_ready (in_ready16),
    .din0 (din0), .din1 (din1), .is_signed (is_signed),
    .out_valid (out_valid16), .out_ready (1'b1),
    .dout (dout16), .ovf (ovf16)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       o;
  } exp_t;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  exp_t q[$];
  int   qe[$];
  exp_t held;
  bit   held_v = 1'b0;

  // Reference: exact integer product, range test against the 8-bit field.
  function automatic exp_t ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint pa, pb, p, lo, hi;
    exp_t   r;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    if (s) begin lo = -128; hi = 127; end
    else   begin lo = 0;    hi = 255; end
    r.o = (p < lo) || (p > hi);
    r.d = p[7:0];
`ifdef CASE_5_MUL_SAT_EN
    if (r.o) r.d = (p < lo) ? lo[7:0] : hi[7:0];
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: settle, check handshake/output against the scoreboard,
  // take the edge, update the reference, return at the next negedge.
  task automatic step(output bit acc);
    bit   xfer;
    exp_t e;
    int   ae;
    #1;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    chk("in_ready_rule", {31'd0, in_ready},
        {31'd0, ap_rst_n && !flush && (!out_valid || out_ready)});
    if (held_v) begin
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold_data", {23'd0, ovf, dout}, {23'd0, held.o, held.d});
    end
    held_v = out_valid && !out_ready && !flush;
    held.d = dout;
    held.o = ovf;
    if (xfer) begin
      if (q.size() == 0) begin
        chk("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e  = q.pop_front();
        ae = qe.pop_front();
        chk("sb_dout", {24'd0, dout}, {24'd0, e.d});
        chk("sb_ovf", {31'd0, ovf}, {31'd0, e.o});
        chk("sb_latency_min", {31'd0, (cyc + 1 - ae) >= NS}, 32'd1);
      end
    end
    @(posedge ap_clk);
    cyc++;
    if (flush) begin
      q.delete();
      qe.delete();
    end else if (acc) begin
      q.push_back(ref_mul(din0, din1, is_signed));
      qe.push_back(cyc);
    end
    @(negedge ap_clk);
  endtask

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [7:0] ed, input logic eo, input string tag);
    bit acc;
    int n;
    int a_edge;
    din0 = a; din1 = b; is_signed = s;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    n = 0;
    do begin
      step(acc);
      n++;
    end while (!acc && n < 10);
    in_valid = 1'b0;
    a_edge = cyc;
    chk({tag, "_accept"}, {31'd0, acc}, 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      step(acc);
      n++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_latency"}, cyc - a_edge, NS - 1);
    chk({tag, "_dout"}, {24'd0, dout}, {24'd0, ed});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    step(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n_acc;
    int exp_next;
    int n;
    logic [7:0]  t_a [3];
    logic [7:0]  t_b [3];
    logic        t_s [3];
    logic [15:0] t_d [3];

    ap_rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0;
    din0 = '0; din1 = '0; is_signed = 1'b0; out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge ap_clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_in_ready16", {31'd0, in_ready16}, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // directed arithmetic
    send_one(8'd100, 8'd2, 1'b1, E_100X2, 1'b1, "s100x2");
    send_one(8'hFF, 8'hFF, 1'b0, E_FFXFF, 1'b1, "uFFxFF");
    send_one(8'h80, 8'h80, 1'b1, E_M128, 1'b1, "sm128sq");
    send_one(8'hFD, 8'h05, 1'b1, 8'hF1, 1'b0, "sm3x5");

    // 16-bit result instance, single stage
    t_a = '{8'hFD, 8'hFF, 8'h80};
    t_b = '{8'h05, 8'hFF, 8'h80};
    t_s = '{1'b1, 1'b0, 1'b1};
    t_d = '{16'hFFF1, 16'hFE01, 16'h4000};
    for (int i = 0; i < 3; i++) begin
      din0 = t_a[i]; din1 = t_b[i]; is_signed = t_s[i]; in_valid16 = 1'b1;
      #1;
      chk("w16_in_ready", {31'd0, in_ready16}, 32'd1);
      @(posedge ap_clk);
      @(negedge ap_clk);
      in_valid16 = 1'b0;
      #1;
      chk("w16_valid", {31'd0, out_valid16}, 32'd1);
      chk("w16_dout", {16'd0, dout16}, {16'd0, t_d[i]});
      chk("w16_ovf", {31'd0, ovf16}, 32'd0);
      @(negedge ap_clk);
    end

    // backpressure: stream 1..10, consumer stalls cycles 4..6
    n_acc = 0; exp_next = 1;
    for (int c = 0; c < 40 && (n_acc < 10 || q.size() > 0); c++) begin
      din0 = 8'(n_acc + 1); din1 = 8'd1; is_signed = 1'b0;
      in_valid  = (n_acc < 10);
      out_ready = !(c >= 4 && c <= 6);
      #1;
      if (out_valid && out_ready) begin
        chk("bp_order", {24'd0, dout}, exp_next);
        exp_next++;
      end
      if (!out_ready && out_valid) chk("bp_in_ready_stall", {31'd0, in_ready}, 32'd0);
      step(acc);
      if (acc) n_acc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_count", exp_next, 11);

    // flush with two results in flight, then 7x7
    din1 = 8'd1; is_signed = 1'b0; in_valid = 1'b1;
    din0 = 8'd3; step(acc);
    din0 = 8'd5; step(acc);
    flush = 1'b1; din0 = 8'd9; din1 = 8'd9;
    step(acc);
    chk("flush_blocks_accept", {31'd0, acc}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    send_one(8'd7, 8'd7, 1'b0, 8'd49, 1'b0, "flush_7x7");

    // asynchronous reset mid-stream
    in_valid = 1'b1; is_signed = 1'b0; din1 = 8'd2;
    for (int i = 0; i < 4; i++) begin
      din0 = 8'(i + 20);
      step(acc);
    end
    in_valid = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_dout", {24'd0, dout}, 32'd0);
    q.delete(); qe.delete(); held_v = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    send_one(8'hFD, 8'h05, 1'b1, 8'hF1, 1'b0, "post_rst");

    // randomized traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      din0      = 8'($urandom);
      din1      = 8'($urandom);
      is_signed = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(acc);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step(acc);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    step(acc);
    step(acc);
    #1;
    chk("drain_no_extra", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/case_5_mul_pipe.md
# case_5_mul_pipe

Parametrised, pipelined multiplier that succeeds the fixed-width combinational `mul` primitive used in generated `case_5` datapaths. It adds a configurable number of pipeline stages, per-transaction signed/unsigned mode, width-narrowing with an overflow flag, and valid/ready flow control with backpressure and flush. It sits between HLS-scheduled operand producers and result consumers that may stall.

## Interface
- `DIN0_WIDTH`, default 8: width of operand 0.
- `DIN1_WIDTH`, default 8: width of operand 1.
- `DOUT_WIDTH`, default 8: result width. Any value ≥ 1 is legal.
- `NUM_STAGE`, default 2: pipeline depth. Legal range is 1..4; elaboration fails outside this range.

- `ap_clk`  in  1  clock; all state updates on the rising edge.
- `ap_rst_n`  in  1  reset; asynchronous, active-low.
- `flush`  in  1  synchronous drop of all in-flight results.
- `in_valid`  in  1  operand transfer request.
- `in_ready`  out  1  block accepts operands this cycle.
- `din0`  in  DIN0_WIDTH  operand 0.
- `din1`  in  DIN1_WIDTH  operand 1.
- `is_signed`  in  1  1 treats both operands as two's complement; 0 treats them as unsigned.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `dout`  out  DOUT_WIDTH  formatted product.
- `ovf`  out  1  full product does not fit in DOUT_WIDTH under the transaction's mode.

## Operation
- Full product width is P = DIN0_WIDTH + DIN1_WIDTH. The product is exact at P bits in the selected mode.
- Formatting happens combinationally before stage 1:
  - If DOUT_WIDTH ≥ P: the product is sign-extended (signed) or zero-extended (unsigned), and `ovf` is 0.
  - If DOUT_WIDTH < P: the low DOUT_WIDTH bits are kept. `ovf` = 1 when the discarded bits are not a pure sign/zero extension of the kept field.
- Stages 1..NUM_STAGE each hold {valid, dout, ovf}. Stages after stage 1 are pure delay.
- Stall-all rule: `advance = !out_valid || out_ready`. When advance = 1, every stage shifts by one.
- `in_ready = advance && !flush && ap_rst_n`. An operand is accepted on a cycle with `in_valid && in_ready`.
- `flush` = 1 clears every valid bit at the next edge. Data registers are left unchanged. `flush` overrides acceptance and takes precedence over `out_ready`.
- No result is lost or duplicated under any pattern of `out_ready`.

## Timing
- Reset state: all valid bits 0, `dout` = 0, `ovf` = 0, `out_valid` = 0. `in_ready` = 0 while `ap_rst_n` is low and 1 in the first cycle after release.
- Assertion of `ap_rst_n` low mid-stream discards all in-flight results immediately, without waiting for a clock edge.
- Latency: a result accepted at edge k is presented at `out_valid` after edge k+NUM_STAGE-1. It is available for transfer in cycle k+NUM_STAGE, provided there is no stall.
- Throughput is 1 result per cycle while `out_ready` = 1.
- While `out_valid && !out_ready`:
  - `dout`, `ovf` and `out_valid` hold stable.
  - `in_ready` = 0.
- Bubbles in the pipeline are not compressed during a stall; stall-all behaviour is intended.
- When flush and acceptance coincide, flush wins: the input is not accepted and no partial state survives.

## Configuration
- `CASE_5_MUL_SAT_EN` defined: when `ovf` = 1, `dout` saturates instead of wrapping.
  - Signed: to the maximum positive or minimum negative DOUT_WIDTH value, following the sign of the true product.
  - Unsigned: to all ones.
- `ovf` behaves identically with and without the macro.
- Undefined: wrap-around truncation, as described in Operation.

## Structure
- Package `case_5_mul_pkg` holds:
  - localparam function `prod_width(a, b)`;
  - the `mul_mode_e` typedef (`MODE_UNSIGNED`, `MODE_SIGNED`);
  - packed struct `mul_res_t` {valid, dout, ovf}, parametrised via width localparams.
- One sub-module, `case_5_mul_stage`:
  - a single pipeline register slice with enable (advance), clear (flush) and asynchronous reset;
  - instantiated NUM_STAGE times in a generate loop.

## Test plan
All scenarios use default parameters unless stated.
- Signed 100 × 2 → `dout` = 0xC8, `ovf` = 1. With `CASE_5_MUL_SAT_EN`: `dout` = 0x7F.
- Unsigned 0xFF × 0xFF (product 0xFE01) → `dout` = 0x01, `ovf` = 1. With the macro: `dout` = 0xFF.
- Signed −128 × −128 (product 16384) → `dout` = 0x00, `ovf` = 1, or 0x7F with the macro. Signed −3 × 5 → `dout` = 0xF1, `ovf` = 0.
- DOUT_WIDTH = 16, signed −3 × 5 → `dout` = 0xFFF1, `ovf` = 0.
- Backpressure, NUM_STAGE = 3:
  - stimulus: stream 1×1 .. 10×1, `out_ready` low for cycles 4–6;
  - response: outputs are exactly 1..10 in order, and `in_ready` = 0 during the stall.
- Flush with 2 results in flight, then a new 7 × 7:
  - response: only 49 emerges, NUM_STAGE cycles after acceptance.
- `ap_rst_n` low for one cycle mid-stream → `out_valid` drops immediately, and the stream resumes cleanly after release.
